seg_cmd_decoder: RTL



---
 rtl/seg_cmd_decoder.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/seg_cmd_decoder.sv
// SPI command parser: decodes framed opcode/payload bytes into the 4-digit and colon display registers.
// Optional idle-byte frame timeout is enabled by defining SEG_CMD_TIMEOUT_EN.
module seg_cmd_decoder #(
  parameter int unsigned DIGIT_BASE     = 10,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd3_200_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_valid,
  input  logic [7:0] rx_byte,
  input  logic       cs_active,
  output logic [3:0] digit0,
  output logic [3:0] digit1,
  output logic [3:0] digit2,
  output logic [3:0] digit3,
  output logic [1:0] colon,
  output logic       busy,
  output logic       cmd_done,
  output logic       cmd_err
);

  typedef enum logic [1:0] {S_IDLE, S_PAYLOAD, S_DISCARD} state_t;

  localparam logic [7:0] OP_SET_DIGITS = 8'h01;
  localparam logic [7:0] OP_SET_COLON  = 8'h02;
  localparam logic [7:0] OP_INCREMENT  = 8'h03;
  localparam logic [7:0] OP_CLEAR      = 8'h04;
  localparam logic [3:0] TOP_DIGIT     = 4'(DIGIT_BASE - 1);

  state_t      state;
  logic        op_is_digits;
  logic [1:0]  remaining;
  logic [7:0]  shadow;
  logic [15:0] digits;
  logic        timeout_hit;

  assign digit0 = digits[3:0];
  assign digit1 = digits[7:4];
  assign digit2 = digits[11:8];
  assign digit3 = digits[15:12];

  function automatic logic [15:0] increment(input logic [15:0] d);
    logic [15:0] r;
    logic        carry;
    r     = d;
    carry = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      if (carry) begin
        if (d[i*4 +: 4] == TOP_DIGIT) begin
          r[i*4 +: 4] = '0;
        end else begin
          r[i*4 +: 4] = d[i*4 +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic digits_valid(input logic [15:0] d);
    logic ok;
    ok = 1'b1;
    if (DIGIT_BASE == 10) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (d[i*4 +: 4] > 4'd9) ok = 1'b0;
      end
    end
    return ok;
  endfunction

`ifdef SEG_CMD_TIMEOUT_EN
  logic [31:0] idle_cnt;

  assign timeout_hit = busy && (idle_cnt == TIMEOUT_CYCLES);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_cnt <= '0;
    end else if (!cs_active || rx_valid || !busy || timeout_hit) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + 32'd1;
    end
  end
`else
  logic unused_timeout;
  assign timeout_hit    = 1'b0;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      op_is_digits <= 1'b0;
      remaining    <= '0;
      shadow       <= '0;
      digits       <= '0;
      colon        <= '1;
      busy         <= 1'b0;
      cmd_done     <= 1'b0;
      cmd_err      <= 1'b0;
    end else begin
      cmd_done <= 1'b0;
      cmd_err  <= 1'b0;
      // Frame close outranks any byte strobe in the same cycle.
      if (!cs_active) begin
        cmd_err   <= (state == S_PAYLOAD);
        state     <= S_IDLE;
        busy      <= 1'b0;
        remaining <= '0;
        shadow    <= '0;
      end else if (rx_valid) begin
        case (state)
          S_IDLE: begin
            case (rx_byte)
              OP_SET_DIGITS: begin
                state        <= S_PAYLOAD;
                busy         <= 1'b1;
                op_is_digits <= 1'b1;
                remaining    <= 2'd2;
              end
              OP_SET_COLON: begin
                state        <= S_PAYLOAD;
                busy         <= 1'b1;
                op_is_digits <= 1'b0;
                remaining    <= 2'd1;
              end
              OP_INCREMENT: begin
                digits   <= increment(digits);
                cmd_done <= 1'b1;
              end
              OP_CLEAR: begin
                digits   <= '0;
                colon    <= '1;
                cmd_done <= 1'b1;
              end
              default: begin
                state   <= S_DISCARD;
                busy    <= 1'b1;
                cmd_err <= 1'b1;
              end
            endcase
          end
          S_PAYLOAD: begin
            if (remaining == 2'd2) begin
              shadow    <= rx_byte;
              remaining <= 2'd1;
            end else begin
              state     <= S_IDLE;
              busy      <= 1'b0;
              remaining <= '0;
              shadow    <= '0;
              if (!op_is_digits) begin
                colon    <= rx_byte[1:0];
                cmd_done <= 1'b1;
              end else if (digits_valid({shadow, rx_byte})) begin
                digits   <= {shadow, rx_byte};
                cmd_done <= 1'b1;
              end else begin
                cmd_err <= 1'b1;
              end
            end
          end
          default: begin
          end
        endcase
      end else if (timeout_hit) begin
        cmd_err   <= (state == S_PAYLOAD);
        state     <= S_IDLE;
        busy      <= 1'b0;
        remaining <= '0;
        shadow    <= '0;
      end
    end
  end

endmodule
